dcache_resp_model: RTL and testbench

- Responder end of the execute/memory-to-dcache request/response bus.
- Accepts the packed request word the AGU drives: load, store, and dcache/icache CACOP.
- Returns the packed response word: ready, rvalid, rdata, dcache/icache cacop-ready.
- Backed by a word-addressed on-chip RAM with configurable read/CACOP latency and optional pseudo-random backpressure; used as the dcache stand-in for core bring-up and AGU verification.

---
 rtl/dcache_resp_model_pkg.sv | 63 ++++++
 rtl/dcache_resp_model_ram.sv | 25 ++
 rtl/dcache_resp_model.sv | 110 +++++++++++
 tb/tb_dcache_resp_model.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_resp_model_pkg.sv
// Shared bus layout, state encoding and stall-LFSR helper for the dcache responder.
package dcache_resp_model_pkg;

  localparam int EXM_DCACHE_WD = 107;
  localparam int EXM_DCACHE_RD = 36;

  // Request field offsets, MSB first; requester and responder pack identically.
  localparam int REQ_VALID    = 106;
  localparam int REQ_OP       = 105;
  localparam int REQ_ADDR_HI  = 104;
  localparam int REQ_ADDR_LO  = 73;
  localparam int REQ_UNCACHED = 72;
  localparam int REQ_STRB_HI  = 71;
  localparam int REQ_STRB_LO  = 68;
  localparam int REQ_WDATA_HI = 67;
  localparam int REQ_WDATA_LO = 36;
  localparam int REQ_DCOP_EN  = 35;
  localparam int REQ_ICOP_EN  = 34;
  localparam int REQ_CODE_HI  = 33;
  localparam int REQ_CODE_LO  = 32;
  localparam int REQ_CADDR_HI = 31;
  localparam int REQ_CADDR_LO = 0;

  localparam int RSP_READY    = 35;
  localparam int RSP_RVALID   = 34;
  localparam int RSP_RDATA_HI = 33;
  localparam int RSP_RDATA_LO = 2;
  localparam int RSP_DCOP_RDY = 1;
  localparam int RSP_ICOP_RDY = 0;

  typedef struct packed {
    logic        valid;
    logic        op;
    logic [31:0] addr;
    logic        uncached;
    logic [3:0]  awstrb;
    logic [31:0] wdata;
    logic        dcache_cacop_en;
    logic        icache_cacop_en;
    logic [1:0]  cacop_code;
    logic [31:0] cacop_addr;
  } req_t;

  typedef struct packed {
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        dcache_cacop_ready;
    logic        icache_cacop_ready;
  } rsp_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_CACOP   = 2'd2
  } state_e;

  // Fibonacci LFSR, taps 16,14,13,11.
  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

endpackage

// File: rtl/dcache_resp_model_ram.sv
// 2^ADDR_W x 32 RAM, per-byte write enable, one synchronous read port.
module dcache_resp_ram #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic [3:0]        i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [31:0]       i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [31:0]       o_rdata
);

  logic [31:0] r_mem [2**ADDR_W];
  logic [31:0] r_rdata;

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (i_we[i]) r_mem[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
    end
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dcache_resp_model.sv
// Dcache stand-in: accepts packed AGU requests, answers from on-chip RAM after
// a fixed read/CACOP latency, with optional LFSR-driven ready withholding.
module dcache_resp_model
  import dcache_resp_model_pkg::*;
#(
  parameter int          ADDR_W    = 12,
  parameter int          RD_LAT    = 2,
  parameter int          CACOP_LAT = 3,
  parameter int          STALL_EN  = 0,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [EXM_DCACHE_WD-1:0] dcache_wdata_bus,
  output logic [EXM_DCACHE_RD-1:0] dcache_rdata_bus
);

  localparam logic [3:0] RD_INIT    = 4'(RD_LAT - 1);
  localparam logic [3:0] CACOP_INIT = 4'(CACOP_LAT - 1);

  req_t              w_req;
  rsp_t              w_rsp;
  state_e            r_state;
  logic [3:0]        r_cnt;
  logic [ADDR_W-1:0] r_idx;
  logic              r_dc_en;
  logic              r_ic_en;
  logic [15:0]       r_lfsr;

  logic              w_stall;
  logic              w_cacop_req;
  logic              w_ready;
  logic              w_accept;
  logic [ADDR_W-1:0] w_idx;
  logic [ADDR_W-1:0] w_raddr;
  logic [3:0]        w_we;
  logic [31:0]       w_ram_rdata;
  logic              w_done;
  logic              w_rvalid;
  logic              w_unused;

  assign w_req       = dcache_wdata_bus;
  assign w_stall     = (STALL_EN != 0) && r_lfsr[0];
  assign w_cacop_req = w_req.dcache_cacop_en | w_req.icache_cacop_en;
  assign w_ready     = resetn && (r_state == ST_IDLE) && !w_cacop_req && !w_stall;
  assign w_accept    = w_req.valid & w_ready;
  assign w_idx       = w_req.addr[ADDR_W+1:2];
  assign w_we        = (w_accept && w_req.op) ? w_req.awstrb : '0;
  assign w_done      = (r_cnt == '0);
  assign w_rvalid    = (r_state == ST_RD_WAIT) && w_done;

  // Read port follows the live request while idle so the word is already
  // registered by the time the latched index takes over in RD_WAIT.
  assign w_raddr = (r_state == ST_IDLE) ? w_idx : r_idx;

  dcache_resp_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_idx),
    .i_wdata (w_req.wdata),
    .i_raddr (w_raddr),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_dc_en <= 1'b0;
      r_ic_en <= 1'b0;
      r_lfsr  <= LFSR_SEED;
    end else begin
      if (STALL_EN != 0) r_lfsr <= lfsr_next(r_lfsr);
      case (r_state)
        ST_IDLE: begin
          if (w_cacop_req) begin
            r_state <= ST_CACOP;
            r_cnt   <= CACOP_INIT;
            r_dc_en <= w_req.dcache_cacop_en;
            r_ic_en <= w_req.icache_cacop_en;
          end else if (w_accept && !w_req.op) begin
            r_state <= ST_RD_WAIT;
            r_cnt   <= RD_INIT;
            r_idx   <= w_idx;
          end
        end
        ST_RD_WAIT, ST_CACOP: begin
          if (w_done) r_state <= ST_IDLE;
          else        r_cnt   <= r_cnt - 4'd1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_rsp                    = '0;
    w_rsp.ready              = w_ready;
    w_rsp.rvalid             = w_rvalid;
    w_rsp.rdata              = w_rvalid ? w_ram_rdata : '0;
    w_rsp.dcache_cacop_ready = (r_state == ST_CACOP) && w_done && r_dc_en;
    w_rsp.icache_cacop_ready = (r_state == ST_CACOP) && w_done && r_ic_en;
  end

  assign dcache_rdata_bus = w_rsp;

  assign w_unused = ^{w_req.addr, w_req.uncached, w_req.cacop_code, w_req.cacop_addr};

endmodule

// File: tb/tb_dcache_resp_model.sv
// Directed and soak bench for dcache_resp_model with a scoreboard per instance.
module tb_dcache_resp_model;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         resetn;
  logic [106:0] req_a, req_b;
  logic [35:0]  rsp_a, rsp_b;

  dcache_resp_model #(.ADDR_W(12), .RD_LAT(2), .CACOP_LAT(3), .STALL_EN(0)) u_a (
    .clk(clk), .resetn(resetn), .dcache_wdata_bus(req_a), .dcache_rdata_bus(rsp_a));

  dcache_resp_model #(.ADDR_W(12), .RD_LAT(3), .CACOP_LAT(2), .STALL_EN(1),
                      .LFSR_SEED(16'hACE1)) u_b (
    .clk(clk), .resetn(resetn), .dcache_wdata_bus(req_b), .dcache_rdata_bus(rsp_b));

  int          n_chk  = 0;
  int          n_pass = 0;
  int          n_rv_b = 0;
  int          n_rd_b = 0;
  bit          mon_en = 1'b0;
  logic [31:0] q_a[$];
  logic [31:0] q_b[$];
  logic [31:0] mm[64];
  logic [15:0] lfsr_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [106:0] mk(input logic v, input logic op, input logic [31:0] a,
                                      input logic [3:0] s, input logic [31:0] w,
                                      input logic dce, input logic ice);
    return {v, op, a, 1'b0, s, w, dce, ice, 2'b00, 32'h0};
  endfunction

  always @(posedge clk) begin
    if (!resetn) lfsr_m <= 16'hACE1;
    else         lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (rsp_a[34]) begin
        chk("rvA_expected", q_a.size() != 0, 1);
        if (q_a.size() != 0) chk("rdataA", rsp_a[33:2], q_a.pop_front());
      end else chk("rdataA_idle", rsp_a[33:2], 0);
      if (rsp_b[34]) begin
        n_rv_b++;
        chk("rvB_expected", q_b.size() != 0, 1);
        if (q_b.size() != 0) chk("rdataB", rsp_b[33:2], q_b.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One request on instance A: sampled ready must be high, accept at next edge.
  task automatic acc_a(input string tag, input logic op, input logic [31:0] addr,
                       input logic [3:0] strb, input logic [31:0] wd, input logic [31:0] exp);
    req_a = mk(1'b1, op, addr, strb, wd, 1'b0, 1'b0);
    @(negedge clk);
    chk({tag, "_ready"}, rsp_a[35], 1);
    if (!op) q_a.push_back(exp);
    step();
    req_a = '0;
  endtask

  // Called in the cycle after a read accept; counts cycles until rvalid.
  task automatic wait_rv_a(input string tag, input int lat);
    int k;
    k = 1;
    repeat (20) begin
      @(negedge clk);
      if (rsp_a[34]) break;
      k++;
      step();
    end
    chk({tag, "_lat"}, k, lat);
    step();
  endtask

  task automatic acc_b(input logic op, input logic [31:0] addr, input logic [3:0] strb,
                       input logic [31:0] wd);
    bit got;
    int k;
    logic [5:0] idx;
    got = 1'b0;
    idx = addr[7:2];
    req_b = mk(1'b1, op, addr, strb, wd, 1'b0, 1'b0);
    repeat (64) begin
      @(negedge clk);
      chk("rdyB_lfsr", rsp_b[35], !lfsr_m[0]);
      if (rsp_b[35]) begin
        got = 1'b1;
        break;
      end
      step();
    end
    chk("accB_timeout", got, 1);
    if (op) begin
      for (int i = 0; i < 4; i++) if (strb[i]) mm[idx][8*i +: 8] = wd[8*i +: 8];
    end else begin
      q_b.push_back(mm[idx]);
      n_rd_b++;
    end
    step();
    req_b = '0;
    if (!op) begin
      k = 1;
      repeat (20) begin
        @(negedge clk);
        chk("rdyB_busy", rsp_b[35], 0);
        if (rsp_b[34]) break;
        k++;
        step();
      end
      chk("rdB_lat", k, 3);
      step();
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a;
    logic [5:0]  wi;
    resetn = 1'b0;
    req_a  = '0;
    req_b  = '0;
    step();
    step();
    @(negedge clk);
    chk("reset_ready", rsp_a[35], 0);
    chk("reset_rsp", rsp_a, 0);
    mon_en = 1'b1;
    step();
    resetn = 1'b1;
    @(negedge clk);
    chk("idle_ready", rsp_a[35], 1);
    step();

    // Write then read with high-address aliasing.
    acc_a("wr40", 1'b1, 32'hC0000040, 4'hF, 32'hDEADBEEF, 0);
    acc_a("rd40", 1'b0, 32'h00000040, 4'h0, 0, 32'hDEADBEEF);
    wait_rv_a("rd40", 2);

    // Byte strobe merge.
    acc_a("wr80", 1'b1, 32'h80, 4'hF, 32'h11223344, 0);
    acc_a("wr80b", 1'b1, 32'h80, 4'b0100, 32'h00AB0000, 0);
    acc_a("rd80", 1'b0, 32'h80, 4'h0, 0, 32'h11AB3344);
    wait_rv_a("rd80", 2);

    // Busy backpressure: write held during a read.
    acc_a("wr44", 1'b1, 32'h44, 4'hF, 32'h55555555, 0);
    acc_a("rd44", 1'b0, 32'h44, 4'h0, 0, 32'h55555555);
    req_a = mk(1'b1, 1'b1, 32'h44, 4'hF, 32'hCAFEF00D, 1'b0, 1'b0);
    @(negedge clk);
    chk("busy_rdy1", rsp_a[35], 0);
    step();
    @(negedge clk);
    chk("busy_rdy2", rsp_a[35], 0);
    chk("busy_rvalid", rsp_a[34], 1);
    step();
    @(negedge clk);
    chk("busy_rdy3", rsp_a[35], 1);
    step();
    req_a = '0;
    acc_a("rd44b", 1'b0, 32'h44, 4'h0, 0, 32'hCAFEF00D);
    wait_rv_a("rd44b", 2);

    // CACOP priority over a simultaneous read.
    req_a = mk(1'b1, 1'b0, 32'h80, 4'h0, 0, 1'b1, 1'b0);
    @(negedge clk);
    chk("cop_rdy0", rsp_a[35], 0);
    step();
    req_a = mk(1'b1, 1'b0, 32'h80, 4'h0, 0, 1'b0, 1'b0);
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      chk("cop_dc_early", rsp_a[1], 0);
      chk("cop_rdy_busy", rsp_a[35], 0);
      step();
    end
    @(negedge clk);
    chk("cop_dc_pulse", rsp_a[1], 1);
    chk("cop_ic_quiet", rsp_a[0], 0);
    chk("cop_rdy3", rsp_a[35], 0);
    step();
    @(negedge clk);
    chk("cop_dc_done", rsp_a[1], 0);
    chk("cop_rdy4", rsp_a[35], 1);
    q_a.push_back(32'h11AB3344);
    step();
    req_a = '0;
    wait_rv_a("cop_rd", 2);

    req_a = mk(1'b0, 1'b0, 0, 4'h0, 0, 1'b0, 1'b1);
    step();
    req_a = '0;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      chk("icop_early", rsp_a[0], 0);
      step();
    end
    @(negedge clk);
    chk("icop_pulse", rsp_a[0], 1);
    chk("icop_dc_quiet", rsp_a[1], 0);
    step();

    // Reset mid-read: pending rvalid is dropped, RAM survives.
    acc_a("rd_abort", 1'b0, 32'h80, 4'h0, 0, 32'h11AB3344);
    resetn = 1'b0;
    @(negedge clk);
    chk("rst_mid_rdy", rsp_a[35], 0);
    step();
    resetn = 1'b1;
    q_a.delete();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("rst_no_rvalid", rsp_a[34], 0);
      chk("rst_rdy", rsp_a[35], 1);
      step();
    end
    acc_a("rd40_post", 1'b0, 32'h40, 4'h0, 0, 32'hDEADBEEF);
    wait_rv_a("rd40_post", 2);
    acc_a("rd_alias", 1'b0, 32'h00004043, 4'h0, 0, 32'hDEADBEEF);
    wait_rv_a("rd_alias", 2);

    // Stall soak on instance B: fill the model window, then random traffic.
    for (int i = 0; i < 64; i++) begin
      wi = 6'(i);
      acc_b(1'b1, {18'h0, 6'h0, wi, 2'b00}, 4'hF, $urandom);
    end
    for (int i = 0; i < 936; i++) begin
      wi = 6'($urandom_range(0, 63));
      a  = ($urandom & 32'hFFFFC000) | {24'h0, wi, 2'b00} | ($urandom & 32'h3);
      if ($urandom_range(0, 1) == 1) acc_b(1'b1, a, 4'($urandom), $urandom);
      else                           acc_b(1'b0, a, 4'h0, 0);
    end
    repeat (4) step();
    chk("rvB_count", n_rv_b, n_rd_b);
    chk("qA_empty", q_a.size(), 0);
    chk("qB_empty", q_b.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
